// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding word-indexed memory request, a single
// instruction holding register towards the decoder, redirect handling and request timeout.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        j_signal,
    input  logic [31:0] jump,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic             instr_valid_q, instr_valid_d;
    logic             fetch_err_q, fetch_err_d;
    logic             wait_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= '0;
            wait_cnt_q    <= '0;
            instr_q       <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Timeout fires on the waiting cycle that would bring the counter to TIMEOUT.
    assign wait_hit = (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        wait_cnt_d    = wait_cnt_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    wait_cnt_d = '0;
                    if (j_signal) begin
                        fetch_pc_d = jump;
                    end else begin
                        instr_d       = imem_rdata;
                        pc_out_d      = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = fetch_pc_q + 32'd1;
                        state_d       = HOLD;
                    end
                end else if (wait_hit) begin
                    fetch_err_d = 1'b1;
                    wait_cnt_d  = '0;
                    if (j_signal) begin
                        fetch_pc_d = jump;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (j_signal) begin
                        redirect_pc_d = jump;
                        state_d       = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // A stale request that times out is abandoned, not retried: its data is unwanted.
                if (imem_ack || wait_hit) begin
                    wait_cnt_d = '0;
                    fetch_pc_d = j_signal ? jump : redirect_pc_q;
                    state_d    = FETCH;
                    if (!imem_ack) begin
                        fetch_err_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (j_signal) begin
                        redirect_pc_d = jump;
                    end
                end
            end
            HOLD: begin
                wait_cnt_d = '0;
                if (j_signal) begin
                    instr_valid_d = 1'b0;
                    fetch_pc_d    = jump;
                    state_d       = FETCH;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_req    = (state_q != HOLD);
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus a drain-timeout sequence.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        j_signal;
    logic [31:0] jump;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fetch_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC(32'h0),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .j_signal   (j_signal),
        .jump       (jump),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc_out     (pc_out),
        .instr_valid(instr_valid),
        .fetch_err  (fetch_err)
    );

    // Inputs are applied for the cycle; expected outputs are what the DUT shows in that cycle.
    typedef struct {
        logic        rst;
        logic        j;
        logic [31:0] jump;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic j, logic [31:0] jp, logic st, logic ak,
                                logic [31:0] rd, logic rq, logic [31:0] ad, logic v,
                                logic [31:0] in, logic [31:0] pc, logic er);
        vec_t t;
        t.rst = r; t.j = j; t.jump = jp; t.stall = st; t.ack = ak; t.rdata = rd;
        t.e_req = rq; t.e_addr = ad; t.e_valid = v; t.e_instr = in; t.e_pc = pc; t.e_err = er;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic j, logic [31:0] jp, logic st, logic ak, logic [31:0] rd);
        rst = r; j_signal = j; jump = jp; stall = st; imem_ack = ak; imem_rdata = rd;
    endtask

    initial begin
        int unsigned seen;
        //            rst j  jump          st ak rdata            req addr          v  instr         pc_out        err
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h00500093,  1, 32'h0,        0, 32'h0,        32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h1,        1, 32'h00500093, 32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h11,        1, 32'h1,        0, 32'h00500093, 32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h2,        1, 32'h11,       32'h1,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h22,        1, 32'h2,        0, 32'h11,       32'h1,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h3,        1, 32'h22,       32'h2,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h33,        1, 32'h3,        0, 32'h22,       32'h2,        0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0, 0, 32'h0,    1, 0, 32'h0,         0, 32'h4,        1, 32'h33,       32'h3,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h4,        1, 32'h33,       32'h3,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,        0, 32'h33,       32'h3,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h44,        1, 32'h4,        0, 32'h33,       32'h3,        0));
        vq.push_back(mk(0, 1, 32'h7,        1, 0, 32'h0,         0, 32'h5,        1, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 1, 32'h20,       0, 0, 32'h0,         1, 32'h7,        0, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h7,        0, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'hDEAD,      1, 32'h7,        0, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 1, 32'h30,       0, 0, 32'h0,         1, 32'h20,       0, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 1, 32'h38,       0, 0, 32'h0,         1, 32'h20,       0, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'hBAD,       1, 32'h20,       0, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 1, 32'h40,       0, 1, 32'h99,        1, 32'h38,       0, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h55,        1, 32'h40,       0, 32'h44,       32'h4,        0));
        vq.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h41,       1, 32'h55,       32'h40,       0));
        vq.push_back(mk(0, 1, 32'hFFFFFFFF, 1, 0, 32'h0,         0, 32'h41,       1, 32'h55,       32'h40,       0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h66,        1, 32'hFFFFFFFF, 0, 32'h55,       32'h40,       0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h66,       32'hFFFFFFFF, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h77,        1, 32'h0,        0, 32'h66,       32'hFFFFFFFF, 0));
        vq.push_back(mk(0, 1, 32'h9,        0, 0, 32'h0,         0, 32'h1,        1, 32'h77,       32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h9,        0, 32'h77,       32'h0,        0));
        vq.push_back(mk(1, 1, 32'h50,       1, 1, 32'h88,        1, 32'h9,        0, 32'h77,       32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        1));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'hAB,        1, 32'h0,        0, 32'h0,        32'h0,        1));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h1,        1, 32'hAB,       32'h0,        1));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h1,        0, 32'hAB,       32'h0,        1));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        0));

        drive(1, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].j, vq[i].jump, vq[i].stall, vq[i].ack, vq[i].rdata);
            #1;
            chk("imem_req",    i, {31'b0, imem_req},    {31'b0, vq[i].e_req});
            chk("imem_addr",   i, imem_addr,            vq[i].e_addr);
            chk("instr_valid", i, {31'b0, instr_valid}, {31'b0, vq[i].e_valid});
            chk("instr",       i, instr,                vq[i].e_instr);
            chk("pc_out",      i, pc_out,               vq[i].e_pc);
            chk("fetch_err",   i, {31'b0, fetch_err},   {31'b0, vq[i].e_err});
        end

        // Redirect during a request that never acks: the stale request times out,
        // the unit lands on the redirect target with the error flag set.
        @(negedge clk);
        drive(0, 1, 32'h60, 0, 0, 32'h0);
        seen = 0;
        for (int c = 1; c <= 10 && seen == 0; c++) begin
            @(negedge clk);
            drive(0, 0, 32'h0, 0, 0, 32'h0);
            #1;
            if (imem_req && imem_addr == 32'h60) seen = c;
            else chk("drain_old_addr", c, imem_addr, 32'h0);
        end
        chk("drain_timeout_cycles", 0, seen, 3);
        chk("drain_timeout_err", 0, {31'b0, fetch_err}, 32'h1);
        chk("drain_timeout_valid", 0, {31'b0, instr_valid}, 32'h0);

        @(negedge clk);
        drive(0, 0, 32'h0, 0, 1, 32'hCAFE);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        chk("after_drain_instr", 0, instr, 32'hCAFE);
        chk("after_drain_pc", 0, pc_out, 32'h60);
        chk("after_drain_valid", 0, {31'b0, instr_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0, word-index PC loaded on reset.
REQ-002 SHALL provide parameter TIMEOUT, default 255, the maximum cycles a memory request may wait for imem_ack.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 j_signal  input  1  one-cycle redirect pulse from the control unit.
REQ-007 jump  input  32  redirect target, word index, sampled when j_signal=1.
REQ-008 stall  input  1  consumer not ready; the instruction is accepted when instr_valid=1 and stall=0.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  word index of the requested instruction.
REQ-011 imem_ack  input  1  one-cycle response; imem_rdata is valid in the same cycle.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 instr  output  32  fetched instruction to the decoder.
REQ-014 pc_out  output  32  word index of instr; the control unit uses it as pc_input.
REQ-015 instr_valid  output  1  instr and pc_out are valid.
REQ-016 fetch_err  output  1  sticky; set when a request times out.

Function
REQ-017 SHALL implement states FETCH, HOLD and DRAIN.
REQ-018 FETCH SHALL drive imem_req=1 and imem_addr=fetch_pc.
- req and addr stay stable until imem_ack.
REQ-019 FETCH with imem_ack and j_signal=0 SHALL, on the next edge:
- load instr<=imem_rdata, pc_out<=fetch_pc, instr_valid<=1;
- set fetch_pc<=fetch_pc+1, with 32-bit wrap;
- move to HOLD.
REQ-020 HOLD SHALL drive imem_req=0 and keep instr/pc_out stable while stall=1.
REQ-021 HOLD with stall=0 and j_signal=0 SHALL clear instr_valid and move to FETCH on the next edge.
- Minimum throughput is one instruction per 2 cycles plus memory latency.
REQ-022 j_signal in FETCH without imem_ack SHALL:
- set redirect_pc<=jump and move to DRAIN;
- keep imem_req=1 with the old imem_addr.
REQ-023 DRAIN SHALL hold the old request until imem_ack, discard that data, then move to FETCH with fetch_pc=redirect_pc.
REQ-024 j_signal in DRAIN SHALL overwrite redirect_pc; the latest jump wins.
REQ-025 j_signal and imem_ack in the same FETCH cycle SHALL discard imem_rdata, set fetch_pc<=jump, keep instr_valid=0 and stay in FETCH.
REQ-026 j_signal in HOLD SHALL clear instr_valid, set fetch_pc<=jump and move to FETCH, regardless of stall.
REQ-027 A wait counter SHALL clear on every new request or ack and increment each cycle while imem_req=1 without ack.
REQ-028 When the wait counter reaches TIMEOUT, the unit SHALL set fetch_err<=1, drop the request and return to FETCH at the same fetch_pc (retry).
- fetch_err clears only on rst.
REQ-029 instr_valid SHALL never be 1 for data belonging to a request issued before the most recent j_signal.
REQ-030 Outputs SHALL be registered, except imem_req/imem_addr, which SHALL be decoded from state and fetch_pc.

Reset
REQ-031 rst SHALL set, on the next edge:
- state=FETCH, fetch_pc=RESET_PC, redirect_pc=0, wait counter=0;
- instr=0, pc_out=0, instr_valid=0, fetch_err=0.
REQ-032 rst SHALL override j_signal, imem_ack and stall in the same cycle.
REQ-033 rst mid-request SHALL abandon the outstanding request, and imem_req SHALL restart for RESET_PC on the first cycle after reset.
- The memory model must tolerate abandoned requests.
REQ-034 When rst deasserts, the first cycle SHALL drive imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-035 Sequential fetch: rst, then ack after 1 cycle with rdata 0x00500093, stall=0 -> instr=0x00500093, pc_out=0 for one cycle, then imem_addr=1.
REQ-036 Stall hold: instr valid with pc_out=3, stall=1 for 5 cycles -> instr/pc_out unchanged, imem_req=0; stall=0 -> next request has addr=4.
REQ-037 Redirect during wait: request addr=7 outstanding, j_signal with jump=0x20, ack 2 cycles later -> data discarded, instr_valid stays 0, next imem_addr=0x20.
REQ-038 Simultaneous events: j_signal (jump=0x40) and imem_ack in the same cycle -> no valid output, next imem_addr=0x40; j_signal in HOLD with stall=1 -> instr_valid=0 next cycle.
REQ-039 Timeout: TIMEOUT=4, no ack -> fetch_err=1 after 4 waiting cycles, request reissued at the same address; rst -> fetch_err=0.
REQ-040 Reset mid-request and wrap: rst while waiting on addr 9 -> next imem_addr=RESET_PC; fetch_pc=32'hFFFFFFFF acked -> next imem_addr=0.
